decode_ereg: RTL

Decode-stage datapath and decode/execute pipeline register for the pipelined Y86-64 core. The block consumes the register IDs from the decode register-ID logic (srcA, srcB, dstE, dstM) and performs the following:
- reads the 15-entry register file and applies PIPE forwarding to produce valA/valB;
- performs the writeback-stage register-file writes;
- latches everything into the E pipeline register, with bubble insertion.

---
 rtl/decode_ereg.sv | 120 ++++++++++++
 1 files changed

// File: rtl/decode_ereg.sv
// Y86-64 decode stage: register file, PIPE operand forwarding and the
// decode/execute (E) pipeline register with bubble insertion.
module decode_ereg (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  D_icode,
   input  logic [3:0]  D_ifun,
   input  logic [3:0]  D_stat,
   input  logic [63:0] D_valC,
   input  logic [63:0] D_valP,
   input  logic [3:0]  srcA,
   input  logic [3:0]  srcB,
   input  logic [3:0]  dstE,
   input  logic [3:0]  dstM,
   input  logic [3:0]  e_dstE,
   input  logic [63:0] e_valE,
   input  logic [3:0]  M_dstE,
   input  logic [3:0]  M_dstM,
   input  logic [63:0] M_valE,
   input  logic [63:0] m_valM,
   input  logic [3:0]  W_dstE,
   input  logic [3:0]  W_dstM,
   input  logic [63:0] W_valE,
   input  logic [63:0] W_valM,
   input  logic        E_bubble,
   output logic [3:0]  E_icode,
   output logic [3:0]  E_ifun,
   output logic [3:0]  E_stat,
   output logic [63:0] E_valC,
   output logic [63:0] E_valA,
   output logic [63:0] E_valB,
   output logic [3:0]  E_dstE,
   output logic [3:0]  E_dstM,
   output logic [3:0]  E_srcA,
   output logic [3:0]  E_srcB,
   output logic [63:0] d_valA,
   output logic [63:0] d_valB
);

   localparam logic [3:0] RNONE = 4'hF;
   localparam logic [3:0] IJXX  = 4'h7;
   localparam logic [3:0] ICALL = 4'h8;
   localparam logic [3:0] INOP  = 4'h1;
   localparam logic [3:0] SAOK  = 4'h1;

   logic [63:0] rf_q [0:14];
   logic [63:0] rf_a, rf_b;

   logic [3:0]  e_icode_q, e_ifun_q, e_stat_q;
   logic [63:0] e_valc_q, e_vala_q, e_valb_q;
   logic [3:0]  e_dste_q, e_dstm_q, e_srca_q, e_srcb_q;

   // Writeback port: the M write is issued last so it wins a same-register conflict.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 15; i++) rf_q[i] <= '0;
      end else begin
         if (W_dstE != RNONE) rf_q[W_dstE] <= W_valE;
         if (W_dstM != RNONE) rf_q[W_dstM] <= W_valM;
      end
   end

   assign rf_a = (srcA == RNONE) ? 64'd0 : rf_q[srcA];
   assign rf_b = (srcB == RNONE) ? 64'd0 : rf_q[srcB];

   function automatic logic [63:0] fwd(input logic [3:0] src, input logic [63:0] rfv);
      if (src == RNONE)         return rfv;
      else if (src == e_dstE)   return e_valE;
      else if (src == M_dstM)   return m_valM;
      else if (src == M_dstE)   return M_valE;
      else if (src == W_dstM)   return W_valM;
      else if (src == W_dstE)   return W_valE;
      else                      return rfv;
   endfunction

   always_comb begin
      d_valA = fwd(srcA, rf_a);
      if (D_icode == IJXX || D_icode == ICALL) d_valA = D_valP;
      d_valB = fwd(srcB, rf_b);
   end

   // ---- decode / execute boundary ----
   always_ff @(posedge clk) begin
      if (rst || E_bubble) begin
         e_icode_q <= INOP;
         e_ifun_q  <= 4'h0;
         e_stat_q  <= SAOK;
         e_valc_q  <= '0;
         e_vala_q  <= '0;
         e_valb_q  <= '0;
         e_dste_q  <= RNONE;
         e_dstm_q  <= RNONE;
         e_srca_q  <= RNONE;
         e_srcb_q  <= RNONE;
      end else begin
         e_icode_q <= D_icode;
         e_ifun_q  <= D_ifun;
         e_stat_q  <= D_stat;
         e_valc_q  <= D_valC;
         e_vala_q  <= d_valA;
         e_valb_q  <= d_valB;
         e_dste_q  <= dstE;
         e_dstm_q  <= dstM;
         e_srca_q  <= srcA;
         e_srcb_q  <= srcB;
      end
   end

   assign E_icode = e_icode_q;
   assign E_ifun  = e_ifun_q;
   assign E_stat  = e_stat_q;
   assign E_valC  = e_valc_q;
   assign E_valA  = e_vala_q;
   assign E_valB  = e_valb_q;
   assign E_dstE  = e_dste_q;
   assign E_dstM  = e_dstm_q;
   assign E_srcA  = e_srca_q;
   assign E_srcB  = e_srcb_q;

endmodule
